alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the 8-bit/2-bit-op combinational ALU.
//  - Adds: configurable width, 8-op set, status flags, valid/ready handshakes on input
//    and output, and an optional iterative multiplier.
//  - Sits between the register-file read stage and write-back in the cpu2 datapath.
//  - Accepts one operation at a time and holds its result until write-back takes it.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 4..32
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst_n       in   1      asynchronous assert, active-low reset
//  inValid     in   1      operands and operation are presented
//  inReady     out  1      block accepts the operation this cycle
//  operandA    in   WIDTH  first operand
//  operandB    in   WIDTH  second operand; bits [$clog2(WIDTH)-1:0] give the shift count
//  operation   in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR(logical), 7 MUL
//  outValid    out  1      result and flags are valid
//  outReady    in   1      consumer takes the result this cycle
//  result      out  WIDTH  operation result (low WIDTH bits)
//  flags       out  4      {N, Z, C, V}
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, outValid=0, result=0, flags=0.
//    Any multiply in flight is discarded.
//  - Handshakes:
//    - Input transfer when inValid & inReady.
//    - inReady = (state==IDLE) & (!outValid | outReady); combinational.
//    - Output transfer when outValid & outReady.
//    - result and flags stay stable while outValid=1 & outReady=0.
//  - FSM states: IDLE, MUL_BUSY.
//    - IDLE + accepted op 0..6: compute; register result/flags; outValid=1 next cycle.
//      Latency is 1 cycle.
//    - IDLE + accepted MUL: latch operands, counter=0, go to MUL_BUSY.
//    - MUL_BUSY: one shift-add step per cycle, for WIDTH cycles.
//      - On the last step, load result/flags, set outValid, return to IDLE.
//      - MUL latency is WIDTH+1 cycles. inReady=0 throughout MUL_BUSY.
//  - Back-to-back ops: accept while draining (outValid & outReady same cycle).
//    The new result replaces the old one with outValid kept at 1.
//  - Arithmetic uses a WIDTH+1-bit internal sum.
//    - ADD: C = carry out.
//    - SUB: C = borrow (A<B unsigned).
//    - V = signed overflow for ADD and SUB; V=0 for all other ops.
//  - SHL/SHR:
//    - C = last bit shifted out.
//    - Shift count 0 leaves A unchanged with C=0.
//  - MUL:
//    - result = low WIDTH bits of the 2*WIDTH unsigned product.
//    - C = 1 if the high WIDTH bits are nonzero.
//  - N = result[WIDTH-1] and Z = (result==0) for every op.
// CONFIGURATION
//  Macro ALU_PIPE_MUL_EN:
//  - Defined: MUL_BUSY state, counter and 2*WIDTH accumulator are built; MUL as above.
//  - Undefined: no multiplier logic.
//    - Operation 7 completes in 1 cycle with result=0, flags={0,1,0,1}.
//    - V=1 marks the op as illegal.
// STRUCTURE
//  - Package alu_pipe_pkg:
//    - op encodings (OP_ADD..OP_MUL).
//    - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
//    - FSM state encoding.
//  - One sub-module, alu_pipe_mul: iterative shift-add multiplier.
//    - Interface: start/done, operands in, 2*WIDTH product out.
//    - Instantiated only under ALU_PIPE_MUL_EN.
//  - The combinational op decode stays in alu_pipe.
// TESTING (WIDTH=8, outReady=1 unless stated)
//  1. ADD 0xFF+0x01, next cycle -> result=0x00, flags={0,1,1,0}.
//     ADD 0x7F+0x01 -> 0x80, flags={1,0,0,1}.
//  2. SUB 0x03-0x05 -> result=0xFE, flags={1,0,1,0}.
//     SHL 0x81 by 1 -> 0x02, C=1.
//     SHR 0x81 by 0 -> 0x81, C=0.
//  3. With ALU_PIPE_MUL_EN: MUL 0x10*0x11 -> outValid exactly 9 cycles after accept.
//     result=0x10, C=1. inReady=0 during cycles 1..8.
//     Without ALU_PIPE_MUL_EN: result=0x00, flags={0,1,0,1} after 1 cycle.
//  4. Backpressure: outReady=0 for 5 cycles after an AND 0xF0&0x3C.
//     result=0x30 held stable, inReady=0.
//     Raise outReady with a new OR pending -> accepted the same cycle; OR result follows.
//  5. Back-to-back XOR ops presented every cycle with outReady=1.
//     -> one result per cycle, no drops or duplicates (scoreboard vs reference model).
//  6. Assert rst_n=0 mid-MUL (cycle 4 of 8) -> outValid=0 and state IDLE immediately.
//     After release, an ADD 2+3 returns 0x05 in 1 cycle.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the registered ALU.
// Holds the operation encodings, the flag bit positions inside {N,Z,C,V},
// the FSM state encoding and a small helper that packs the four flag bits.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  function automatic logic [3:0] packFlags(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul: iterative shift-add unsigned multiplier.
// A start pulse latches the operands; the product is built one multiplier bit
// per cycle over WIDTH cycles, and done pulses for one cycle once the full
// 2*WIDTH product is sitting in the accumulator.
module alu_pipe_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q;
  logic               done_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  // Add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Latch operands on start, then perform one shift-add step per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        mcand_q  <= {{WIDTH{1'b0}}, a_i};
        mplier_q <= b_i;
        acc_q    <= '0;
        count_q  <= '0;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and {N,Z,C,V} flags.
// Ops 0..6 complete in one cycle. With ALU_PIPE_MUL_EN defined, op 7 runs
// on the iterative multiplier (WIDTH+1 cycles); without it, op 7 returns
// zero with the V flag set to mark it as unsupported.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       operation,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q;
  logic             outValid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shlWide;
  logic [WIDTH:0]   shrWide;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] aluRes;
  logic             aluC;
  logic             aluV;
  logic [3:0]       aluFlags;

  assign inReady = (state_q == ST_IDLE) & (~outValid_q | outReady);
  assign accept  = inValid & inReady;

  // Single-cycle operation decode; carry/borrow come from a WIDTH+1-bit sum
  always_comb begin
    sum     = {1'b0, operandA} + {1'b0, operandB};
    diff    = {1'b0, operandA} - {1'b0, operandB};
    shamt   = operandB[SHW-1:0];
    shlWide = {1'b0, operandA} << shamt;
    shrWide = {operandA, 1'b0} >> shamt;
    aluRes  = '0;
    aluC    = 1'b0;
    aluV    = 1'b0;
    case (op_e'(operation))
      OP_ADD: begin
        aluRes = sum[WIDTH-1:0];
        aluC   = sum[WIDTH];
        aluV   = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                 (sum[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = diff[WIDTH-1:0];
        aluC   = diff[WIDTH];
        aluV   = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                 (diff[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_AND: aluRes = operandA & operandB;
      OP_OR:  aluRes = operandA | operandB;
      OP_XOR: aluRes = operandA ^ operandB;
      OP_SHL: begin
        aluRes = shlWide[WIDTH-1:0];
        aluC   = shlWide[WIDTH];
      end
      OP_SHR: begin
        aluRes = shrWide[WIDTH:1];
        aluC   = shrWide[0];
      end
      OP_MUL: begin
`ifndef ALU_PIPE_MUL_EN
        aluV = 1'b1;
`endif
      end
      default: aluRes = '0;
    endcase
    aluFlags = packFlags(aluRes[WIDTH-1], aluRes == '0, aluC, aluV);
  end

`ifdef ALU_PIPE_MUL_EN
  logic               mulStart;
  logic               mulDone;
  logic [2*WIDTH-1:0] mulProduct;
  logic [3:0]         mulFlags;

  assign mulStart = accept && (operation == OP_MUL);
  assign mulFlags = packFlags(mulProduct[WIDTH-1],
                              mulProduct[WIDTH-1:0] == '0,
                              |mulProduct[2*WIDTH-1:WIDTH],
                              1'b0);

  alu_pipe_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mulStart),
    .a_i      (operandA),
    .b_i      (operandB),
    .done_o   (mulDone),
    .product_o(mulProduct)
  );
`endif

  // Control FSM and output register: drain, accept, and load results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      outValid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      if (outValid_q && outReady) begin
        outValid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (operation == OP_MUL) begin
              state_q <= ST_MUL_BUSY;
            end else begin
              result_q   <= aluRes;
              flags_q    <= aluFlags;
              outValid_q <= 1'b1;
            end
`else
            result_q   <= aluRes;
            flags_q    <= aluFlags;
            outValid_q <= 1'b1;
`endif
          end
        end
        ST_MUL_BUSY: begin
`ifdef ALU_PIPE_MUL_EN
          if (mulDone) begin
            result_q   <= mulProduct[WIDTH-1:0];
            flags_q    <= mulFlags;
            outValid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign outValid = outValid_q;
  assign result   = result_q;
  assign flags    = flags_q;

endmodule
